// File: rtl/rare_stream_ctrl.sv
// Purpose: serial command link to single SRAM write/read master; owns the mux select and serializes read data.
// Latency: write strobe 1 cycle after the last frame bit; read data leaves rd_latency+1 cycles after the strobe.
// Backpressure: none; sin_valid gaps stall deserialization, and bits arriving while busy past SHIFT_IN are dropped.
module rare_stream_ctrl #(
  parameter int data_width = 32,
  parameter int rd_latency = 1
) (
  input  logic                  stream_clk,
  input  logic                  rst_n,
  input  logic                  mode_en,
  output logic                  stream_enable,
  input  logic                  sin,
  input  logic                  sin_valid,
  output logic                  sout,
  output logic                  sout_valid,
  output logic                  busy,
  output logic [31:0]           stream_addr,
  output logic [data_width-1:0] stream_data_in,
  input  logic [data_width-1:0] stream_data_out,
  output logic                  stream_we,
  output logic                  stream_en
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_ISSUE,
    S_WAIT,
    S_SHIFT_OUT
  } state_t;

  // Bit counter values at which the final frame bit / final output bit is handled.
  localparam logic [6:0] rd_last  = 7'd31;
  localparam logic [6:0] wr_last  = 7'(32 + data_width - 1);
  localparam logic [6:0] out_last = 7'(data_width - 1);
  localparam logic [1:0] lat_last = 2'(rd_latency - 1);

  state_t                state_q, state_nxt;
  logic                  op_q;
  logic [6:0]            bit_cnt;
  logic [1:0]            lat_cnt;
  logic [31:0]           addr_sr;
  logic [data_width-1:0] data_sr;
  logic [data_width-1:0] out_sr;

  logic op_ld, bit_shift, bit_clr, lat_inc, lat_clr, cap, shift_out;

  assign stream_addr    = addr_sr;
  assign stream_data_in = data_sr;

  // State register.
  always_ff @(posedge stream_clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state decode, datapath strobes and state-derived outputs.
  always_comb begin
    state_nxt  = state_q;
    op_ld      = 1'b0;
    bit_shift  = 1'b0;
    bit_clr    = 1'b0;
    lat_inc    = 1'b0;
    lat_clr    = 1'b0;
    cap        = 1'b0;
    shift_out  = 1'b0;
    busy       = (state_q != S_IDLE);
    stream_en  = (state_q == S_ISSUE);
    stream_we  = (state_q == S_ISSUE) && op_q;
    sout_valid = (state_q == S_SHIFT_OUT);
    sout       = (state_q == S_SHIFT_OUT) && out_sr[data_width-1];
    case (state_q)
      S_IDLE: begin
        if (stream_enable && sin_valid) begin
          op_ld     = 1'b1;
          state_nxt = S_SHIFT_IN;
        end
      end
      S_SHIFT_IN: begin
        // Losing ownership mid-frame throws the partial frame away.
        if (!mode_en) begin
          bit_clr   = 1'b1;
          state_nxt = S_IDLE;
        end else if (sin_valid) begin
          bit_shift = 1'b1;
          if (bit_cnt == (op_q ? wr_last : rd_last)) begin
            bit_clr   = 1'b1;
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_nxt = op_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt == lat_last) begin
          cap       = 1'b1;
          lat_clr   = 1'b1;
          state_nxt = S_SHIFT_OUT;
        end else begin
          lat_inc = 1'b1;
        end
      end
      S_SHIFT_OUT: begin
        shift_out = 1'b1;
        if (bit_cnt == out_last) begin
          bit_clr   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Op latch, bit/latency counters and the in/out shift registers.
  always_ff @(posedge stream_clk) begin
    if (!rst_n) begin
      op_q    <= 1'b0;
      bit_cnt <= '0;
      lat_cnt <= '0;
      addr_sr <= '0;
      data_sr <= '0;
      out_sr  <= '0;
    end else begin
      if (op_ld) op_q <= sin;

      if (bit_clr)                     bit_cnt <= '0;
      else if (bit_shift || shift_out) bit_cnt <= bit_cnt + 7'd1;

      // First 32 frame bits after the op fill the address, the rest fill the data.
      if (bit_shift) begin
        if (bit_cnt < 7'd32) addr_sr <= {addr_sr[30:0], sin};
        else                 data_sr <= {data_sr[data_width-2:0], sin};
      end

      if (lat_clr)      lat_cnt <= '0;
      else if (lat_inc) lat_cnt <= lat_cnt + 2'd1;

      if (cap)            out_sr <= stream_data_out;
      else if (shift_out) out_sr <= {out_sr[data_width-2:0], 1'b0};
    end
  end

  // Ownership follows mode_en, but only grants in IDLE and only revokes before the access is committed.
  always_ff @(posedge stream_clk) begin
    if (!rst_n) begin
      stream_enable <= 1'b0;
    end else if (mode_en && state_q == S_IDLE) begin
      stream_enable <= 1'b1;
    end else if (!mode_en && (state_q == S_IDLE || state_q == S_SHIFT_IN)) begin
      stream_enable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rare_stream_ctrl.sv
// Purpose: self-checking bench for rare_stream_ctrl with an SRAM model and an access/serial-output scoreboard.
// Latency: expectations are stamped with the cycle the DUT must respond in.
// Backpressure: not applicable; stimulus paces itself on busy with a bounded wait.
module tb_rare_stream_ctrl;
  localparam int DW  = 32;
  localparam int RDL = 1;

  logic          stream_clk = 1'b0;
  logic          rst_n, mode_en, sin, sin_valid;
  logic          stream_enable, sout, sout_valid, busy, stream_we, stream_en;
  logic [31:0]   stream_addr;
  logic [DW-1:0] stream_data_in;
  logic [DW-1:0] stream_data_out = '0;

  rare_stream_ctrl #(.data_width(DW), .rd_latency(RDL)) dut (
    .stream_clk      (stream_clk),
    .rst_n           (rst_n),
    .mode_en         (mode_en),
    .stream_enable   (stream_enable),
    .sin             (sin),
    .sin_valid       (sin_valid),
    .sout            (sout),
    .sout_valid      (sout_valid),
    .busy            (busy),
    .stream_addr     (stream_addr),
    .stream_data_in  (stream_data_in),
    .stream_data_out (stream_data_out),
    .stream_we       (stream_we),
    .stream_en       (stream_en)
  );

  always #5 stream_clk = ~stream_clk;

  // Edge counter: at a negedge, cyc equals the number of rising edges so far.
  int cyc = 0;
  always @(posedge stream_clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event occurred that should not have", name);
  endtask

  // SRAM model with one cycle of read latency.
  logic [DW-1:0] mem [logic [31:0]];
  always @(posedge stream_clk) begin
    if (stream_en) begin
      if (stream_we) mem[stream_addr] = stream_data_in;
      else stream_data_out <= mem.exists(stream_addr) ? mem[stream_addr] : '0;
    end
  end

  // Scoreboard entries.
  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [DW-1:0] data;
    int            cyc;
  } acc_t;

  typedef struct {
    logic [DW-1:0] word;
    int            start;
    bit            abort;
  } out_t;

  acc_t acc_q[$];
  out_t out_q[$];
  acc_t a_h;
  out_t o_h;

  int            bit_idx = 0;
  int            word_start = 0;
  logic [DW-1:0] word_sh = '0;

  // Monitor: compare every SRAM strobe and every serialized word against the queues.
  always @(negedge stream_clk) begin
    if (stream_en) begin
      if (acc_q.size() == 0) begin
        flag("unexpected_stream_en");
      end else begin
        a_h = acc_q.pop_front();
        chk("issue_cycle", 64'(cyc), 64'(a_h.cyc));
        chk("issue_we", 64'(stream_we), 64'(a_h.we));
        chk("issue_addr", 64'(stream_addr), 64'(a_h.addr));
        if (a_h.we) chk("issue_data", 64'(stream_data_in), 64'(a_h.data));
      end
    end
    if (sout_valid) begin
      if (bit_idx == 0) word_start = cyc;
      word_sh = {word_sh[DW-2:0], sout};
      bit_idx++;
      if (bit_idx == DW) begin
        bit_idx = 0;
        if (out_q.size() == 0) begin
          flag("unexpected_sout_word");
        end else begin
          o_h = out_q.pop_front();
          chk("sout_word", 64'(word_sh), 64'(o_h.word));
          chk("sout_start_cycle", 64'(word_start), 64'(o_h.start));
          chk("sout_completed_not_aborted", 64'(o_h.abort), 64'(0));
        end
      end
    end else if (bit_idx != 0) begin
      bit_idx = 0;
      chk("sout_gap_only_on_abort", 64'(out_q.size() != 0 && out_q[0].abort), 64'(1));
      if (out_q.size() != 0) void'(out_q.pop_front());
    end
  end

  // Frame table: write/read pairs with expected read-back words.
  typedef struct {
    logic          op;
    logic [31:0]   addr;
    logic [DW-1:0] data;
    int            gap;
    bit            junk;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic idle_cycles(input int n);
    repeat (n) begin
      sin_valid = 1'b0;
      sin = 1'($urandom);
      @(posedge stream_clk); #1;
    end
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    sin_valid = 1'b1;
    @(posedge stream_clk); #1;
    sin_valid = 1'b0;
  endtask

  task automatic send_frame(input logic op, input logic [31:0] addr, input logic [DW-1:0] data, input int gap);
    idle_cycles(gap);
    send_bit(op);
    for (int i = 31; i >= 0; i--) begin
      idle_cycles(gap);
      send_bit(addr[i]);
    end
    if (op) begin
      for (int i = DW - 1; i >= 0; i--) begin
        idle_cycles(gap);
        send_bit(data[i]);
      end
    end
  endtask

  // Wait for IDLE, optionally spraying sin_valid bits that the DUT must ignore.
  task automatic wait_idle(input bit junk, output int at);
    int n;
    n = 0;
    while (busy && n < 200) begin
      if (junk) begin
        sin_valid = 1'b1;
        sin = 1'($urandom);
      end
      @(posedge stream_clk); #1;
      sin_valid = 1'b0;
      n++;
    end
    if (n >= 200) flag("busy_timeout");
    at = cyc;
  endtask

  task automatic run_vec(input vec_t v);
    int   last;
    int   idle_at;
    acc_t a;
    out_t o;
    send_frame(v.op, v.addr, v.data, v.gap);
    last   = cyc;
    a.we   = v.op;
    a.addr = v.addr;
    a.data = v.data;
    a.cyc  = last;
    acc_q.push_back(a);
    if (!v.op) begin
      o.word  = v.exp_rd;
      o.start = last + 1 + RDL;
      o.abort = 1'b0;
      out_q.push_back(o);
    end
    wait_idle(v.junk, idle_at);
    if (v.op) chk("wr_busy_fall_cycle", 64'(idle_at), 64'(last + 1));
    else      chk("rd_busy_fall_cycle", 64'(idle_at), 64'(last + 2 + RDL + DW - 1));
  endtask

  initial begin
    int   last;
    acc_t a;
    out_t o;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         0, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 1, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0020, 32'h0,         2, 1'b1, 32'h1234_5678};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         1, 1'b0, 32'h8000_0001};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'hA5A5_5A5A, 3, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,         0, 1'b1, 32'hA5A5_5A5A};
    vecs[8] = '{1'b0, 32'h0000_0010, 32'h0,         0, 1'b1, 32'hDEAD_BEEF};

    rst_n = 1'b0;
    mode_en = 1'b1;
    sin = 1'b0;
    sin_valid = 1'b0;
    repeat (3) @(posedge stream_clk);
    #1;
    chk("rst_stream_enable", 64'(stream_enable), 64'(0));
    chk("rst_sout", 64'(sout), 64'(0));
    chk("rst_sout_valid", 64'(sout_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_stream_addr", 64'(stream_addr), 64'(0));
    chk("rst_stream_data_in", 64'(stream_data_in), 64'(0));
    chk("rst_stream_we", 64'(stream_we), 64'(0));
    chk("rst_stream_en", 64'(stream_en), 64'(0));

    rst_n = 1'b1;
    @(posedge stream_clk); #1;
    chk("enable_one_cycle_after_release", 64'(stream_enable), 64'(1));

    // First frame starts on the very cycle ownership is first seen.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // mode_en drops after 10 bits of a write frame: no access, back to IDLE.
    send_bit(1'b1);
    for (int i = 0; i < 9; i++) send_bit(1'b0);
    mode_en = 1'b0;
    @(posedge stream_clk); #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_stream_enable", 64'(stream_enable), 64'(0));
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    chk("no_ownership_ignores_sin", 64'(busy), 64'(0));
    mode_en = 1'b1;
    @(posedge stream_clk); #1;
    chk("reenable_stream_enable", 64'(stream_enable), 64'(1));
    run_vec(vecs[6]);
    run_vec(vecs[7]);

    // Reset in the middle of serializing a read.
    send_frame(1'b0, 32'h0000_0010, '0, 0);
    last   = cyc;
    a.we   = 1'b0;
    a.addr = 32'h0000_0010;
    a.data = '0;
    a.cyc  = last;
    acc_q.push_back(a);
    o.word  = 32'hDEAD_BEEF;
    o.start = last + 1 + RDL;
    o.abort = 1'b1;
    out_q.push_back(o);
    repeat (10) @(posedge stream_clk);
    #1;
    chk("pre_reset_in_shift_out", 64'(sout_valid), 64'(1));
    rst_n = 1'b0;
    @(posedge stream_clk); #1;
    chk("mid_read_reset_sout_valid", 64'(sout_valid), 64'(0));
    chk("mid_read_reset_busy", 64'(busy), 64'(0));
    chk("mid_read_reset_stream_enable", 64'(stream_enable), 64'(0));
    chk("mid_read_reset_stream_addr", 64'(stream_addr), 64'(0));
    rst_n = 1'b1;
    @(posedge stream_clk); #1;
    chk("post_reset_enable", 64'(stream_enable), 64'(1));
    run_vec(vecs[8]);

    repeat (3) @(posedge stream_clk);
    #1;
    chk("access_queue_drained", 64'(acc_q.size()), 64'(0));
    chk("sout_queue_drained", 64'(out_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
